// File: rtl/tecla_scheduler.sv
// Purpose: debounces six piano keys and picks the one note that drives the tone pin and the VGA key highlight.
// Latency: a stable key change reaches note_code DEBOUNCE_CYCLES+3 clocks later; key_display follows on the next frame_start.
// Backpressure: none; keys are free-running levels and the outputs are always valid.
module tecla_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk50mhz,
    input  logic       reset,
    input  logic [5:0] tecla,
    input  logic       frame_start,
    output logic [2:0] note_code,
    output logic [5:0] key_display,
    output logic       tone_out,
    output logic       note_valid
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [5:0]    sync1, sync2;
    logic [5:0]    db, db_d;
    logic [CW-1:0] cnt [6];
    logic [5:0]    press, press_other, cur_mask;
    state_t        state, state_nxt;
    logic [2:0]    note_nxt;
    logic          note_chg;
    logic [16:0]   tone_cnt, half_last;

    // Code of the lowest set bit (index+1), 0 when no bit is set.
    function automatic logic [2:0] lowest_code(input logic [5:0] v);
        logic [2:0] code;
        code = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) code = 3'(i + 1);
        end
        return code;
    endfunction

    // One-hot key mask for a note code; all zero for silence.
    function automatic logic [5:0] code_onehot(input logic [2:0] code);
        logic [5:0] m;
        m = 6'd0;
        for (int i = 0; i < 6; i++) begin
            if (code == 3'(i + 1)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Two-flop synchroniser: keys are asynchronous to the clock.
    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            sync1 <= 6'd0;
            sync2 <= 6'd0;
        end else begin
            sync1 <= tecla;
            sync2 <= sync1;
        end
    end

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive mismatching clocks.
    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            db   <= 6'd0;
            db_d <= 6'd0;
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press       = db & ~db_d;
    assign cur_mask    = code_onehot(note_code);
    assign press_other = press & ~cur_mask;

    // State and note register.
    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            note_code <= 3'd0;
        end else begin
            state     <= state_nxt;
            note_code <= note_nxt;
        end
    end

    // Key policy: newest press wins (lowest index on ties); releasing the current key falls back to the lowest held key.
    always_comb begin
        state_nxt = state;
        note_nxt  = note_code;
        case (state)
            IDLE: begin
                note_nxt = 3'd0;
                if (|press) begin
                    state_nxt = PLAY;
                    note_nxt  = lowest_code(press);
                end
            end
            PLAY: begin
                if (|press_other) begin
                    note_nxt = lowest_code(press_other);
                end else if (!(|(db & cur_mask))) begin
                    note_nxt = lowest_code(db);
                    if (note_nxt == 3'd0) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                note_nxt  = 3'd0;
            end
        endcase
    end

    assign note_chg   = (note_nxt != note_code);
    assign note_valid = |note_code;

    // Half-period ROM, stored as the terminal count (half-period minus one).
    always_comb begin
        half_last = 17'd0;
        case (note_code)
            3'd1:    half_last = 17'd95555;
            3'd2:    half_last = 17'd85130;
            3'd3:    half_last = 17'd75842;
            3'd4:    half_last = 17'd71585;
            3'd5:    half_last = 17'd63775;
            3'd6:    half_last = 17'd56817;
            default: half_last = 17'd0;
        endcase
    end

    // Square wave; restarts low on the same edge that changes the note so every note begins phase-aligned.
    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            tone_cnt <= 17'd0;
            tone_out <= 1'b0;
        end else if (state_nxt == IDLE || note_chg) begin
            tone_cnt <= 17'd0;
            tone_out <= 1'b0;
        end else if (tone_cnt == half_last) begin
            tone_cnt <= 17'd0;
            tone_out <= ~tone_out;
        end else begin
            tone_cnt <= tone_cnt + 17'd1;
        end
    end

    // Highlight only changes in vertical blank so the screen never tears mid-frame.
    always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            key_display <= 6'd0;
        end else if (frame_start) begin
            key_display <= code_onehot(note_code);
        end
    end

endmodule

// File: tb/tb_tecla_scheduler.sv
// Purpose: directed bench for tecla_scheduler with a cycle-level reference model and literal spot checks.
// Latency: inputs change on falling edges; outputs are compared 2 time units after each rising edge.
// Backpressure: none.
module tb_tecla_scheduler;

    localparam int D = 4;

    logic       clk50mhz = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] tecla = 6'd0;
    logic       frame_start = 1'b0;
    logic [2:0] note_code;
    logic [5:0] key_display;
    logic       tone_out;
    logic       note_valid;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int hp [6] = '{95556, 85131, 75843, 71586, 63776, 56818};

    // Reference model state
    logic [5:0]   m_s1, m_sync, m_db, m_dbd, m_disp;
    logic [D-1:0] m_hist [6];
    int           m_note, m_age;

    tecla_scheduler #(.DEBOUNCE_CYCLES(D)) dut (
        .clk50mhz    (clk50mhz),
        .reset       (reset),
        .tecla       (tecla),
        .frame_start (frame_start),
        .note_code   (note_code),
        .key_display (key_display),
        .tone_out    (tone_out),
        .note_valid  (note_valid)
    );

    always #10 clk50mhz = ~clk50mhz;

    function automatic int lowest(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    function automatic int exp_tone(input int note, input int age);
        if (note == 0) return 0;
        return ((age / hp[note-1]) % 2 == 1) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk50mhz);
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    // Model: keys accepted after D mismatching synchronised samples; note chosen by the key policy; tone from time since the last note change.
    always @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
            m_s1 = 6'd0; m_sync = 6'd0; m_db = 6'd0; m_dbd = 6'd0; m_disp = 6'd0;
            for (int i = 0; i < 6; i++) m_hist[i] = '0;
            m_note = 0;
            m_age  = 0;
        end else begin
            int nn;
            int cur;
            logic [5:0] pr, oth;
            pr = m_db & ~m_dbd;
            if (m_note == 0) begin
                nn = lowest(pr);
            end else begin
                cur = m_note - 1;
                oth = pr;
                oth[cur] = 1'b0;
                if (oth != 6'd0)     nn = lowest(oth);
                else if (!m_db[cur]) nn = lowest(m_db);
                else                 nn = m_note;
            end
            if (frame_start) m_disp = (m_note == 0) ? 6'd0 : (6'd1 << (m_note - 1));
            if (nn != m_note) m_age = 0;
            else              m_age = m_age + 1;
            m_note = nn;
            m_dbd = m_db;
            for (int i = 0; i < 6; i++) begin
                m_hist[i] = {m_hist[i][D-2:0], m_sync[i]};
                if (m_hist[i] == {D{~m_db[i]}}) m_db[i] = ~m_db[i];
            end
            m_sync = m_s1;
            m_s1   = tecla;
        end
    end

    // Compare every DUT output against the model after each rising edge.
    always @(posedge clk50mhz) begin
        #2;
        if (reset && cmp_en) begin
            chk("note_code", int'(note_code), m_note);
            chk("note_valid", int'(note_valid), (m_note != 0) ? 1 : 0);
            chk("tone_out", int'(tone_out), exp_tone(m_note, m_age));
            chk("key_display", int'(key_display), int'(m_disp));
        end
    end

    initial begin
        int n;
        #5 reset = 1'b0;
        step(2);
        chk("rst_note_code", int'(note_code), 0);
        chk("rst_note_valid", int'(note_valid), 0);
        chk("rst_tone_out", int'(tone_out), 0);
        chk("rst_key_display", int'(key_display), 0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Glitches of D-1 clocks are rejected
        tecla = 6'b000100; step(3); tecla = 6'd0; step(3);
        tecla = 6'b000100; step(3); tecla = 6'd0; step(12);
        chk("glitch_rejected", int'(note_code), 0);

        // Exact latency D+3
        tecla = 6'b000100;
        step(6);
        chk("latency_early", int'(note_code), 0);
        step(1);
        chk("latency_exact", int'(note_code), 3);
        chk("tone_low_at_start", int'(tone_out), 0);
        frame_pulse();
        chk("display_key2", int'(key_display), 6'b000100);

        // First rise one half-period after the note change
        n = 1;
        while (!tone_out && n < 80000) begin
            step(1);
            n++;
        end
        chk("first_rise", n, 75843);

        // Switch to key 5 while tone is high: tone drops on the change edge
        tecla = 6'b100100;
        step(6);
        chk("before_switch_note", int'(note_code), 3);
        chk("before_switch_tone", int'(tone_out), 1);
        step(1);
        chk("switch_note", int'(note_code), 6);
        chk("switch_tone_forced_low", int'(tone_out), 0);
        chk("display_holds_old", int'(key_display), 6'b000100);
        step(5);
        chk("display_still_old", int'(key_display), 6'b000100);
        frame_pulse();
        chk("display_key5", int'(key_display), 6'b100000);

        tecla = 6'd0; step(10);
        chk("all_released", int'(note_code), 0);

        // Last-pressed wins and fallback
        tecla = 6'b010000; step(10);
        chk("hold_key4", int'(note_code), 5);
        tecla = 6'b010010; step(10);
        chk("press_key1", int'(note_code), 2);
        tecla = 6'b010000; step(10);
        chk("release_key1", int'(note_code), 5);
        tecla = 6'd0; step(10);
        chk("release_key4", int'(note_code), 0);
        chk("release_key4_tone", int'(tone_out), 0);

        // Simultaneous press: lowest index wins, fallback to lowest held
        tecla = 6'b101001; step(10);
        chk("simul_press", int'(note_code), 1);
        tecla = 6'b101000; step(10);
        chk("simul_release0", int'(note_code), 4);

        // frame_start on the change edge latches the old note
        tecla = 6'b100000;
        step(6);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        chk("coincident_note", int'(note_code), 6);
        chk("coincident_display_old", int'(key_display), 6'b001000);
        step(3);
        frame_pulse();
        chk("coincident_next_frame", int'(key_display), 6'b100000);

        // Asynchronous reset mid-note
        tecla = 6'b001000; step(10);
        chk("key3_sounding", int'(note_code), 4);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_note", int'(note_code), 0);
        chk("async_rst_valid", int'(note_valid), 0);
        chk("async_rst_tone", int'(tone_out), 0);
        chk("async_rst_display", int'(key_display), 0);
        tecla = 6'd0;
        step(2);
        reset = 1'b1;
        step(1000);
        chk("idle_after_reset", int'(note_code), 0);
        chk("idle_after_reset_tone", int'(tone_out), 0);

        // Key held through reset is accepted as a fresh press
        tecla = 6'b000010; step(10);
        chk("key1_before_reset", int'(note_code), 2);
        #3 reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(6);
        chk("held_key_debouncing", int'(note_code), 0);
        step(1);
        chk("held_key_accepted", int'(note_code), 2);
        tecla = 6'd0; step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
